pix_point_op: RTL and testbench

Parametrised per-pixel point-operation stage on the Frame interface (val/rdy plus sof/eof/sol/eol), placed between the stream-to-frame converter and downstream filters. Each of CH_NUM channels gets the same operation: pass, invert, saturating offset, or binary threshold. Configuration is shadowed at start of frame, so a frame is never processed with mixed settings. It is a single registered stage with full backpressure support.

---
 rtl/pix_point_op.sv | 169 ++++++++++++++++
 tb/tb_pix_point_op.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pix_point_op.sv
// pix_point_op: single registered per-pixel point operation on the Frame
// interface (val/rdy with sof/eof/sol/eol markers). Every channel gets the
// same operation: pass, invert, saturating offset or binary threshold.
// The configuration is captured on each accepted sof beat, so a whole frame
// is always processed with one set of settings.
// Optional build macro: PIX_LINE_CHECK_EN adds a per-line pixel counter and
// a sticky line_err flag. Without it, line_err is tied to 0.
module pix_point_op #(
  parameter int CH_NUM = 3,
  parameter int CH_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               cfg_mode,
  input  logic [CH_W-1:0]          cfg_offset,
  input  logic                     cfg_sub,
  input  logic [CH_W-1:0]          cfg_thr,
  input  logic [10:0]              cfg_img_w,
  input  logic                     m_frm_val,
  output logic                     m_frm_rdy,
  input  logic [CH_NUM*CH_W-1:0]   m_frm_data,
  input  logic                     m_frm_sof,
  input  logic                     m_frm_eof,
  input  logic                     m_frm_sol,
  input  logic                     m_frm_eol,
  output logic                     s_frm_val,
  input  logic                     s_frm_rdy,
  output logic [CH_NUM*CH_W-1:0]   s_frm_data,
  output logic                     s_frm_sof,
  output logic                     s_frm_eof,
  output logic                     s_frm_sol,
  output logic                     s_frm_eol,
  output logic                     line_err
);

  localparam int DATA_WIDTH = CH_NUM * CH_W;

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_INVERT = 2'd1;
  localparam logic [1:0] MODE_OFFSET = 2'd2;
  localparam logic [1:0] MODE_THRESH = 2'd3;

  logic            accept;
  logic            use_live;
  logic [1:0]      sh_mode;
  logic [CH_W-1:0] sh_offset;
  logic            sh_sub;
  logic [CH_W-1:0] sh_thr;
  logic [1:0]      eff_mode;
  logic [CH_W-1:0] eff_offset;
  logic            eff_sub;
  logic [CH_W-1:0] eff_thr;
  logic [DATA_WIDTH-1:0] proc_data;

  // One channel's point operation; offset math carries one extra bit so the
  // carry/borrow decides the saturation.
  function automatic logic [CH_W-1:0] chan_op(
    input logic [1:0]      mode,
    input logic [CH_W-1:0] c,
    input logic [CH_W-1:0] off,
    input logic            sub,
    input logic [CH_W-1:0] thr
  );
    logic [CH_W:0] ext;
    chan_op = c;
    ext     = '0;
    case (mode)
      MODE_PASS:   chan_op = c;
      MODE_INVERT: chan_op = ~c;
      MODE_OFFSET: begin
        if (sub) begin
          ext     = {1'b0, c} - {1'b0, off};
          chan_op = ext[CH_W] ? '0 : ext[CH_W-1:0];
        end else begin
          ext     = {1'b0, c} + {1'b0, off};
          chan_op = ext[CH_W] ? '1 : ext[CH_W-1:0];
        end
      end
      MODE_THRESH: chan_op = (c >= thr) ? '1 : '0;
      default:     chan_op = c;
    endcase
  endfunction

  assign m_frm_rdy = ~s_frm_val | s_frm_rdy;
  assign accept    = m_frm_val & m_frm_rdy;
  // The sof beat itself uses the live settings it is about to capture.
  assign use_live  = accept & m_frm_sof;

  assign eff_mode   = use_live ? cfg_mode   : sh_mode;
  assign eff_offset = use_live ? cfg_offset : sh_offset;
  assign eff_sub    = use_live ? cfg_sub    : sh_sub;
  assign eff_thr    = use_live ? cfg_thr    : sh_thr;

  // Apply the selected operation to every channel of the incoming pixel.
  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    proc_data = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      proc_data[k*CH_W +: CH_W] = chan_op(eff_mode, m_frm_data[k*CH_W +: CH_W],
                                          eff_offset, eff_sub, eff_thr);
    end
  end

  // Capture the configuration at the start of each frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_mode   <= MODE_PASS;
      sh_offset <= '0;
      sh_sub    <= 1'b0;
      sh_thr    <= '0;
    end else if (use_live) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      sh_mode   <= cfg_mode;
      sh_offset <= cfg_offset;
      sh_sub    <= cfg_sub;
      sh_thr    <= cfg_thr;
    end
  end

  // Output register: load on accept, drop valid when drained, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_frm_val  <= 1'b0;
      s_frm_data <= '0;
      s_frm_sof  <= 1'b0;
      s_frm_eof  <= 1'b0;
      s_frm_sol  <= 1'b0;
      s_frm_eol  <= 1'b0;
    end else if (accept) begin
      s_frm_val  <= 1'b1;
      s_frm_data <= proc_data;
      s_frm_sof  <= m_frm_sof;
      s_frm_eof  <= m_frm_eof;
      s_frm_sol  <= m_frm_sol;
      s_frm_eol  <= m_frm_eol;
    end else if (s_frm_rdy) begin
      s_frm_val  <= 1'b0;
    end
  end

`ifdef PIX_LINE_CHECK_EN
  logic [10:0] pix_cnt;
  logic [10:0] next_cnt;
  logic        len_bad;

  // Count including the current beat; sol restarts at 1, the count saturates.
  assign next_cnt = m_frm_sol ? 11'd1 :
                    (&pix_cnt) ? pix_cnt : pix_cnt + 11'd1;
  assign len_bad  = m_frm_eol & (next_cnt != cfg_img_w);

  // Per-line pixel counter and sticky length error, cleared by sof.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt  <= '0;
      line_err <= 1'b0;
    end else if (accept) begin
      pix_cnt <= next_cnt;
      if (m_frm_sof)    line_err <= len_bad;
      else if (len_bad) line_err <= 1'b1;
    end
  end
`else
  logic unused_img_w;
  assign unused_img_w = ^cfg_img_w;
  assign line_err     = 1'b0;
`endif

endmodule

// File: tb/tb_pix_point_op.sv
// tb_pix_point_op: self-checking bench for pix_point_op. Fixed vectors, hand
// sequences for latency, backpressure, shadowing and reset, then random
// frames with random stalls against a scoreboard reference model.
module tb_pix_point_op;
  localparam int CH_NUM = 3;
  localparam int CH_W   = 8;
  localparam int DW     = CH_NUM * CH_W;

  logic          clk, rst_n;
  logic [1:0]    cfg_mode;
  logic [7:0]    cfg_offset, cfg_thr;
  logic          cfg_sub;
  logic [10:0]   cfg_img_w;
  logic          m_frm_val, m_frm_rdy;
  logic [DW-1:0] m_frm_data;
  logic          m_frm_sof, m_frm_eof, m_frm_sol, m_frm_eol;
  logic          s_frm_val, s_frm_rdy;
  logic [DW-1:0] s_frm_data;
  logic          s_frm_sof, s_frm_eof, s_frm_sol, s_frm_eol;
  logic          line_err;

  pix_point_op #(.CH_NUM(CH_NUM), .CH_W(CH_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_mode(cfg_mode), .cfg_offset(cfg_offset), .cfg_sub(cfg_sub),
    .cfg_thr(cfg_thr), .cfg_img_w(cfg_img_w),
    .m_frm_val(m_frm_val), .m_frm_rdy(m_frm_rdy), .m_frm_data(m_frm_data),
    .m_frm_sof(m_frm_sof), .m_frm_eof(m_frm_eof),
    .m_frm_sol(m_frm_sol), .m_frm_eol(m_frm_eol),
    .s_frm_val(s_frm_val), .s_frm_rdy(s_frm_rdy), .s_frm_data(s_frm_data),
    .s_frm_sof(s_frm_sof), .s_frm_eof(s_frm_eof),
    .s_frm_sol(s_frm_sol), .s_frm_eol(s_frm_eol),
    .line_err(line_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: each channel treated as an integer 0..255, clamped arithmetic.
  function automatic logic [DW-1:0] ref_pix(int mode, int off, bit sub, int thr, logic [DW-1:0] d);
    logic [DW-1:0] r;
    int c, o;
    r = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      c = int'(d[k*CH_W +: CH_W]);
      case (mode)
        0:       o = c;
        1:       o = 255 - c;
        2:       o = sub ? ((c - off < 0) ? 0 : c - off) : ((c + off > 255) ? 255 : c + off);
        default: o = (c >= thr) ? 255 : 0;
      endcase
      r[k*CH_W +: CH_W] = 8'(o);
    end
    return r;
  endfunction

  typedef struct {
    logic [DW-1:0] data;
    logic [3:0]    mk;   // {sof, eof, sol, eol}
  } beat_t;

  beat_t sb[$];
  int    md_mode, md_off, md_thr;
  bit    md_sub;
  int    md_cnt;
  bit    md_err;
  bit    mon_en = 0;
  bit    prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic [3:0]    prev_mk;
  int    out_cnt = 0;
  bit    rand_stall = 0;

  task automatic model_reset();
    sb.delete();
    md_mode = 0; md_off = 0; md_thr = 0; md_sub = 0;
    md_cnt = 0; md_err = 0; prev_stall = 0;
  endtask

  // Monitor: sampled mid-cycle, when the handshake for the next edge is settled.
  always @(negedge clk) begin
    if (mon_en) begin
      beat_t b, e;
      check("rdy_rule", m_frm_rdy, !s_frm_val || s_frm_rdy);
      check("line_err", line_err, md_err);
      if (prev_stall) begin
        check("stall_val", s_frm_val, 1'b1);
        check("stall_data", s_frm_data, prev_data);
        check("stall_mk", {s_frm_sof, s_frm_eof, s_frm_sol, s_frm_eol}, prev_mk);
      end
      prev_stall = s_frm_val && !s_frm_rdy;
      prev_data  = s_frm_data;
      prev_mk    = {s_frm_sof, s_frm_eof, s_frm_sol, s_frm_eol};
      if (s_frm_val && s_frm_rdy) begin
        out_cnt++;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_beat: got unexpected beat 0x%0h, expected none", s_frm_data);
        end else begin
          e = sb.pop_front();
          check("out_data", s_frm_data, e.data);
          check("out_mk", {s_frm_sof, s_frm_eof, s_frm_sol, s_frm_eol}, e.mk);
        end
      end
      if (m_frm_val && m_frm_rdy) begin
        if (m_frm_sof) begin
          md_mode = int'(cfg_mode); md_off = int'(cfg_offset);
          md_thr = int'(cfg_thr); md_sub = cfg_sub;
        end
        b.data = ref_pix(md_mode, md_off, md_sub, md_thr, m_frm_data);
        b.mk   = {m_frm_sof, m_frm_eof, m_frm_sol, m_frm_eol};
        sb.push_back(b);
`ifdef PIX_LINE_CHECK_EN
        md_cnt = m_frm_sol ? 1 : ((md_cnt + 1 > 2047) ? 2047 : md_cnt + 1);
        if (m_frm_sof) md_err = 0;
        if (m_frm_eol && md_cnt != int'(cfg_img_w)) md_err = 1;
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_cfg(input int mode, input int off, input bit sub, input int thr);
    cfg_mode = 2'(mode); cfg_offset = 8'(off); cfg_sub = sub; cfg_thr = 8'(thr);
  endtask

  // Present one beat and return 1 ns after the edge that accepted it.
  task automatic send_beat(input logic [DW-1:0] d, input bit sof, input bit eof,
                           input bit sol, input bit eol);
    bit acc;
    m_frm_val = 1; m_frm_data = d;
    m_frm_sof = sof; m_frm_eof = eof; m_frm_sol = sol; m_frm_eol = eol;
    for (int n = 0; n < 200; n++) begin
      if (rand_stall) s_frm_rdy = 1'($urandom_range(0, 1));
      @(negedge clk); acc = m_frm_rdy;
      tick();
      if (acc) return;
    end
    checks++; errors++;
    $display("FAIL accept_timeout: got no accept in 200 cycles, expected accept");
  endtask

  task automatic idle(input int n);
    m_frm_val = 0;
    repeat (n) begin
      if (rand_stall) s_frm_rdy = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic drain();
    rand_stall = 0; s_frm_rdy = 1; m_frm_val = 0;
    for (int n = 0; n < 50; n++) begin
      if (sb.size() == 0 && !s_frm_val) return;
      tick();
    end
    check("drain_left", 64'(sb.size()), 0);
  endtask

  typedef struct {
    logic [1:0] mode; logic [7:0] off; logic sub; logic [7:0] thr;
    logic [DW-1:0] din; logic [DW-1:0] dout;
  } vec_t;
  vec_t vecs[11];

  initial begin
    int base;
    vecs[0]  = '{2'd0, 8'h00, 1'b0, 8'h00, 24'h102030, 24'h102030};
    vecs[1]  = '{2'd1, 8'h00, 1'b0, 8'h00, 24'h00FF5A, 24'hFF00A5};
    vecs[2]  = '{2'd2, 8'h20, 1'b0, 8'h00, 24'hF01000, 24'hFF3020};
    vecs[3]  = '{2'd2, 8'h20, 1'b1, 8'h00, 24'h101040, 24'h000020};
    vecs[4]  = '{2'd3, 8'h00, 1'b0, 8'h80, 24'h7F80FF, 24'h00FFFF};
    vecs[5]  = '{2'd2, 8'hFF, 1'b0, 8'h00, 24'h000001, 24'hFFFFFF};
    vecs[6]  = '{2'd2, 8'h01, 1'b0, 8'h00, 24'hFEFF00, 24'hFFFF01};
    vecs[7]  = '{2'd2, 8'h01, 1'b1, 8'h00, 24'h000102, 24'h000001};
    vecs[8]  = '{2'd2, 8'h40, 1'b1, 8'h00, 24'h404040, 24'h000000};
    vecs[9]  = '{2'd3, 8'h00, 1'b0, 8'h00, 24'h000000, 24'hFFFFFF};
    vecs[10] = '{2'd3, 8'h00, 1'b0, 8'hFF, 24'hFEFF00, 24'h00FF00};

    rst_n = 0; m_frm_val = 0; m_frm_data = '0;
    m_frm_sof = 0; m_frm_eof = 0; m_frm_sol = 0; m_frm_eol = 0;
    s_frm_rdy = 1; set_cfg(0, 0, 0, 0); cfg_img_w = 11'd4;
    model_reset();
    repeat (2) tick();
    check("rst_val", s_frm_val, 1'b0);
    check("rst_data", s_frm_data, 24'h0);
    check("rst_mk", {s_frm_sof, s_frm_eof, s_frm_sol, s_frm_eol}, 4'h0);
    check("rst_line_err", line_err, 1'b0);
    check("rst_rdy", m_frm_rdy, 1'b1);
    rst_n = 1; mon_en = 1;
    tick();

    // 4-pixel line in pass mode: 1-cycle latency, full throughput.
    base = out_cnt;
    send_beat(24'h102030, 1, 0, 1, 0);
    check("lat_val", s_frm_val, 1'b1);
    check("lat_data", s_frm_data, 24'h102030);
    check("lat_sof_sol", {s_frm_sof, s_frm_sol}, 2'b11);
    send_beat(24'h405060, 0, 0, 0, 0);
    send_beat(24'h708090, 0, 0, 0, 0);
    send_beat(24'hA0B0C0, 0, 1, 0, 1);
    check("last_eof_eol", {s_frm_sof, s_frm_eof, s_frm_eol}, 3'b011);
    idle(1);
    check("line_beats", 64'(out_cnt - base), 4);
    check("line_idle_val", s_frm_val, 1'b0);

    // Table vectors, each a 1-pixel frame so the live config applies.
    foreach (vecs[i]) begin
      set_cfg(int'(vecs[i].mode), int'(vecs[i].off), vecs[i].sub, int'(vecs[i].thr));
      send_beat(vecs[i].din, 1, 1, 1, 1);
      check($sformatf("vec%0d", i), s_frm_data, vecs[i].dout);
      idle(1);
    end

    // Backpressure: output held and upstream blocked for 3 cycles.
    set_cfg(1, 0, 0, 0); cfg_img_w = 11'd2;
    s_frm_rdy = 0;
    send_beat(24'h123456, 1, 0, 1, 0);
    m_frm_data = 24'h0A0B0C; m_frm_sof = 0; m_frm_eof = 1; m_frm_sol = 0; m_frm_eol = 1;
    repeat (3) begin
      @(negedge clk);
      check("bp_rdy", m_frm_rdy, 1'b0);
      check("bp_data", s_frm_data, 24'hEDCBA9);
      tick();
    end
    s_frm_rdy = 1;
    send_beat(24'h0A0B0C, 0, 1, 0, 1);
    check("bp_next", s_frm_data, 24'hF5F4F3);
    idle(1);

    // 16-beat line with random stalls: no beat lost or duplicated.
    set_cfg(2, 8'h30, 0, 0); cfg_img_w = 11'd16;
    base = out_cnt; rand_stall = 1;
    for (int i = 0; i < 16; i++)
      send_beat(24'($urandom), i == 0, i == 15, i == 0, i == 15);
    drain();
    check("stall_run_beats", 64'(out_cnt - base), 16);

    // Mid-frame config change waits for the next sof.
    set_cfg(0, 0, 0, 0); cfg_img_w = 11'd3;
    send_beat(24'h112233, 1, 0, 1, 0);
    cfg_mode = 2'd1;
    send_beat(24'hABCDEF, 0, 0, 0, 0);
    check("shadow_hold", s_frm_data, 24'hABCDEF);
    send_beat(24'h445566, 0, 1, 0, 1);
    check("shadow_hold2", s_frm_data, 24'h445566);
    send_beat(24'h00FF5A, 1, 0, 1, 0);
    check("shadow_sof_live", s_frm_data, 24'hFF00A5);
    cfg_mode = 2'd0;
    send_beat(24'h010203, 0, 0, 0, 0);
    check("shadow_new", s_frm_data, 24'hFEFDFC);
    send_beat(24'h000000, 0, 1, 0, 1);
    idle(2);

    // Reset mid-frame drops the output and restores the default shadow.
    set_cfg(1, 0, 0, 0);
    s_frm_rdy = 0;
    send_beat(24'h555555, 1, 0, 1, 0);
    m_frm_val = 0; mon_en = 0; rst_n = 0;
    #1;
    check("midrst_val", s_frm_val, 1'b0);
    check("midrst_data", s_frm_data, 24'h0);
    tick();
    rst_n = 1; s_frm_rdy = 1; model_reset(); mon_en = 1;
    tick();
    send_beat(24'h00FF5A, 0, 0, 0, 0);
    check("midrst_shadow", s_frm_data, 24'h00FF5A);
    send_beat(24'h000000, 0, 1, 0, 1);
    idle(2);

    // Line-length check.
    set_cfg(0, 0, 0, 0); cfg_img_w = 11'd4;
    send_beat(24'h1, 1, 0, 1, 0);
    send_beat(24'h2, 0, 0, 0, 0);
    send_beat(24'h3, 0, 0, 0, 1);
`ifdef PIX_LINE_CHECK_EN
    check("lc_short", line_err, 1'b1);
`else
    check("lc_tied", line_err, 1'b0);
`endif
    for (int i = 0; i < 4; i++) send_beat(24'(i), 0, i == 3, i == 0, i == 3);
`ifdef PIX_LINE_CHECK_EN
    check("lc_sticky", line_err, 1'b1);
`endif
    send_beat(24'h9, 1, 0, 1, 0);
`ifdef PIX_LINE_CHECK_EN
    check("lc_sof_clear", line_err, 1'b0);
`endif
    for (int i = 0; i < 3; i++) send_beat(24'(i), 0, i == 2, 0, i == 2);
    check("lc_good_line", line_err, 1'b0);
    send_beat(24'h7, 1, 1, 1, 1);
`ifdef PIX_LINE_CHECK_EN
    check("lc_sof_eol_bad", line_err, 1'b1);
`endif
    idle(2);

    // Random frames, random config, random gaps and stalls.
    rand_stall = 1;
    for (int f = 0; f < 8; f++) begin
      int lines, w;
      set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
      cfg_img_w = 11'($urandom_range(1, 5));
      lines = int'($urandom_range(1, 3));
      for (int l = 0; l < lines; l++) begin
        w = int'($urandom_range(1, 5));
        for (int p = 0; p < w; p++) begin
          if ($urandom_range(0, 3) == 0) cfg_mode = 2'($urandom_range(0, 3));
          if ($urandom_range(0, 3) == 0) cfg_offset = 8'($urandom_range(0, 255));
          send_beat(24'($urandom), l == 0 && p == 0, l == lines - 1 && p == w - 1,
                    p == 0, p == w - 1);
          if ($urandom_range(0, 3) == 0) idle(1);
        end
      end
    end
    drain();
    idle(2);
    check("final_sb_empty", 64'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish before 500 us");
    $fatal(1);
  end
endmodule
